// File: rtl/sticker_pkg.sv
// Shared types and sizing helpers for the sticker code capture block.
package sticker_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_e;

  // Width needed to hold a digit count in the range 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sticker_code_capture_if.sv
// Digit/completion strobes in, captured code and status pulses out.
interface sticker_code_capture_if #(
  parameter int unsigned MAX_LEN = 3,
  parameter int unsigned DIGIT_W = 4
);
  import sticker_pkg::*;

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  logic                       d_valid;
  logic [DIGIT_W-1:0]         d_val;
  logic                       c_done;
  logic [LEN_W-1:0]           len;
  logic [MAX_LEN*DIGIT_W-1:0] code_out;
  logic [LEN_W-1:0]           code_len;
  logic                       code_ovf;
  logic                       code_valid;
  logic                       empty_err;

  modport master (
    output d_valid, d_val, c_done,
    input  len, code_out, code_len, code_ovf, code_valid, empty_err
  );

  modport slave (
    input  d_valid, d_val, c_done,
    output len, code_out, code_len, code_ovf, code_valid, empty_err
  );

endinterface

// File: rtl/digit_shift_buffer.sv
// Left-shifting digit store; newest digit sits in the low digit slot.
module digit_shift_buffer #(
  parameter int unsigned MAX_LEN = 3,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       shift,
  input  logic                       clear,
  input  logic [DIGIT_W-1:0]         din,
  output logic [MAX_LEN*DIGIT_W-1:0] dout
);

  localparam int unsigned BUF_W = MAX_LEN * DIGIT_W;

  logic [BUF_W-1:0] r_buf;

  // Clear wins over shift: a completing digit is already folded into the captured code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf <= '0;
    end else if (clear) begin
      r_buf <= '0;
    end else if (shift) begin
      r_buf <= (r_buf << DIGIT_W) | BUF_W'(din);
    end
  end

  assign dout = r_buf;

endmodule

// File: rtl/sticker_code_capture.sv
// Collects digit strobes into a code and publishes it on each completion strobe.
module sticker_code_capture
  import sticker_pkg::*;
#(
  parameter int unsigned MAX_LEN = 3,
  parameter int unsigned DIGIT_W = 4
) (
  input logic             clk,
  input logic             reset,
  sticker_code_capture_if.slave bus
);

  localparam int unsigned      LEN_W   = len_w(MAX_LEN);
  localparam int unsigned      BUF_W   = MAX_LEN * DIGIT_W;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_e           r_state, w_state_d;
  logic [LEN_W-1:0] r_cnt, w_cnt_d, w_cnt_upd;
  logic             r_ovf, w_ovf_d, w_ovf_upd;
  logic             w_accept, w_done_ok, w_empty;
  logic [BUF_W-1:0] w_buf, w_buf_upd;

  logic [BUF_W-1:0] r_code_out;
  logic [LEN_W-1:0] r_code_len;
  logic             r_code_ovf;
  logic             r_code_valid;
  logic             r_empty_err;

  digit_shift_buffer #(
    .MAX_LEN (MAX_LEN),
    .DIGIT_W (DIGIT_W)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .shift (w_accept),
    .clear (w_done_ok),
    .din   (bus.d_val),
    .dout  (w_buf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ovf   <= w_ovf_d;
    end
  end

  // Digit is applied first; completion then sees the post-digit buffer, count and flag.
  always_comb begin
    w_accept  = bus.d_valid && (r_state != S_FULL);
    w_cnt_upd = r_cnt + LEN_W'(w_accept);
    w_ovf_upd = r_ovf | (bus.d_valid && (r_state == S_FULL));
    w_buf_upd = w_accept ? ((w_buf << DIGIT_W) | BUF_W'(bus.d_val)) : w_buf;
    w_done_ok = bus.c_done && ((r_state != S_IDLE) || bus.d_valid);
    w_empty   = bus.c_done && (r_state == S_IDLE) && !bus.d_valid;
    w_state_d = r_state;
    w_cnt_d   = w_cnt_upd;
    w_ovf_d   = w_ovf_upd;
    unique case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_accept) w_state_d = (w_cnt_upd == LEN_MAX) ? S_FULL : S_COLLECT;
      end
      S_FULL:  w_state_d = S_FULL;
      default: w_state_d = S_IDLE;
    endcase
    if (w_done_ok) begin
      w_state_d = S_IDLE;
      w_cnt_d   = '0;
      w_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code_out   <= '0;
      r_code_len   <= '0;
      r_code_ovf   <= 1'b0;
      r_code_valid <= 1'b0;
      r_empty_err  <= 1'b0;
    end else begin
      r_code_valid <= w_done_ok;
      r_empty_err  <= w_empty;
      if (w_done_ok) begin
        r_code_out <= w_buf_upd;
        r_code_len <= w_cnt_upd;
        r_code_ovf <= w_ovf_upd;
      end
    end
  end

  assign bus.len        = r_cnt;
  assign bus.code_out   = r_code_out;
  assign bus.code_len   = r_code_len;
  assign bus.code_ovf   = r_code_ovf;
  assign bus.code_valid = r_code_valid;
  assign bus.empty_err  = r_empty_err;

endmodule

// File: tb/tb_sticker_code_capture.sv
// Scoreboard bench: stimulus queues expected pulses, monitors pop and compare them.
module tb_sticker_code_capture;

  typedef struct {
    bit          empty;
    logic [11:0] code;
    int          len;
    bit          ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sticker_code_capture_if #(.MAX_LEN(3), .DIGIT_W(4)) a_if ();
  sticker_code_capture_if #(.MAX_LEN(1), .DIGIT_W(4)) b_if ();

  sticker_code_capture #(.MAX_LEN(3), .DIGIT_W(4)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  sticker_code_capture #(.MAX_LEN(1), .DIGIT_W(4)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step_a(input bit dv, input logic [3:0] v, input bit cd);
    @(negedge clk);
    a_if.d_valid = dv;
    a_if.d_val   = v;
    a_if.c_done  = cd;
  endtask

  task automatic step_b(input bit dv, input logic [3:0] v, input bit cd);
    @(negedge clk);
    b_if.d_valid = dv;
    b_if.d_val   = v;
    b_if.c_done  = cd;
  endtask

  // Called right after the c_done cycle is driven; the pulse is due one cycle later.
  task automatic expect_a(input bit empty, input logic [11:0] code, input int len, input bit ovf);
    exp_t e;
    e.empty = empty; e.code = code; e.len = len; e.ovf = ovf; e.cyc = cyc + 1;
    qa.push_back(e);
  endtask

  task automatic expect_b(input bit empty, input logic [11:0] code, input int len, input bit ovf);
    exp_t e;
    e.empty = empty; e.code = code; e.len = len; e.ovf = ovf; e.cyc = cyc + 1;
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && (a_if.code_valid || a_if.empty_err)) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_pulse: got valid=%0b empty=%0b at cycle %0d expected none",
                 a_if.code_valid, a_if.empty_err, cyc);
      end else begin
        ea = qa.pop_front();
        check("a_code_valid", 32'(a_if.code_valid), 32'(!ea.empty));
        check("a_empty_err", 32'(a_if.empty_err), 32'(ea.empty));
        check("a_latency", cyc, ea.cyc);
        check("a_len_after_done", 32'(a_if.len), 0);
        check("a_code_out", 32'(a_if.code_out), 32'(ea.code));
        check("a_code_len", 32'(a_if.code_len), ea.len);
        check("a_code_ovf", 32'(a_if.code_ovf), 32'(ea.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && (b_if.code_valid || b_if.empty_err)) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_pulse: got valid=%0b empty=%0b at cycle %0d expected none",
                 b_if.code_valid, b_if.empty_err, cyc);
      end else begin
        eb = qb.pop_front();
        check("b_code_valid", 32'(b_if.code_valid), 32'(!eb.empty));
        check("b_empty_err", 32'(b_if.empty_err), 32'(eb.empty));
        check("b_latency", cyc, eb.cyc);
        check("b_len_after_done", 32'(b_if.len), 0);
        check("b_code_out", 32'(b_if.code_out), 32'(eb.code));
        check("b_code_len", 32'(b_if.code_len), eb.len);
        check("b_code_ovf", 32'(b_if.code_ovf), 32'(eb.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.d_valid = 1'b0; a_if.d_val = '0; a_if.c_done = 1'b0;
    b_if.d_valid = 1'b0; b_if.d_val = '0; b_if.c_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_len", 32'(a_if.len), 0);
    check("rst_code_out", 32'(a_if.code_out), 0);
    check("rst_code_len", 32'(a_if.code_len), 0);
    check("rst_code_ovf", 32'(a_if.code_ovf), 0);
    check("rst_code_valid", 32'(a_if.code_valid), 0);
    check("rst_empty_err", 32'(a_if.empty_err), 0);
    reset = 1'b0;

    // Two digits, then completion.
    step_a(1, 4'h7, 0);
    step_a(1, 4'h2, 0);
    step_a(0, 4'h0, 0);
    check("len_two", 32'(a_if.len), 2);
    step_a(0, 4'h0, 1); expect_a(0, 12'h072, 2, 0);
    step_a(0, 4'h0, 0);

    // Five digits into a three-digit code: last two dropped.
    for (int i = 1; i <= 5; i++) step_a(1, 4'(i), 0);
    step_a(0, 4'h0, 0);
    check("len_saturated", 32'(a_if.len), 3);
    step_a(0, 4'h0, 1); expect_a(0, 12'h123, 3, 1);
    step_a(0, 4'h0, 0);

    // Completion with nothing collected; previous code must hold.
    step_a(0, 4'h0, 1); expect_a(1, 12'h123, 3, 1);
    step_a(0, 4'h0, 0);
    step_a(0, 4'h0, 0);
    check("held_code_out", 32'(a_if.code_out), 32'h123);
    check("held_code_len", 32'(a_if.code_len), 3);

    // Digit and completion together, from idle and from collect.
    step_a(1, 4'h9, 1); expect_a(0, 12'h009, 1, 0);
    step_a(0, 4'h0, 0);
    step_a(1, 4'h1, 0);
    step_a(1, 4'h2, 0);
    step_a(1, 4'h3, 1); expect_a(0, 12'h123, 3, 0);
    step_a(0, 4'h0, 0);

    // Asynchronous reset in the middle of a cycle discards the partial code.
    step_a(1, 4'h5, 0);
    step_a(1, 4'h6, 0);
    @(posedge clk);
    #2;
    check("pre_reset_len", 32'(a_if.len), 2);
    reset = 1'b1;
    a_if.d_valid = 1'b0; a_if.d_val = '0; a_if.c_done = 1'b0;
    #1;
    check("async_len", 32'(a_if.len), 0);
    check("async_code_out", 32'(a_if.code_out), 0);
    check("async_code_len", 32'(a_if.code_len), 0);
    check("async_code_ovf", 32'(a_if.code_ovf), 0);
    check("async_code_valid", 32'(a_if.code_valid), 0);
    check("async_empty_err", 32'(a_if.empty_err), 0);
    @(negedge clk);
    reset = 1'b0;
    step_a(1, 4'h8, 1); expect_a(0, 12'h008, 1, 0);
    step_a(0, 4'h0, 0);

    // Idle cycles in the middle of a code change nothing.
    step_a(1, 4'h4, 0);
    repeat (3) step_a(0, 4'h0, 0);
    check("idle_len", 32'(a_if.len), 1);
    check("idle_code_out", 32'(a_if.code_out), 32'h008);
    step_a(0, 4'h0, 1); expect_a(0, 12'h004, 1, 0);
    step_a(0, 4'h0, 0);
    step_a(0, 4'h0, 0);

    // Single-digit build.
    step_b(1, 4'hA, 0);
    step_b(1, 4'hB, 0);
    step_b(0, 4'h0, 0);
    check("b_len_full", 32'(b_if.len), 1);
    step_b(0, 4'h0, 1); expect_b(0, 12'h00A, 1, 1);
    step_b(0, 4'h0, 0);
    step_b(0, 4'h0, 0);
    step_b(0, 4'h0, 0);

    check("a_missing_pulses", qa.size(), 0);
    check("b_missing_pulses", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sticker_code_capture.md
STICKER_CODE_CAPTURE -- requirements
Module: sticker_code_capture

Interface
REQ-001 Parameter MAX_LEN, default 3, is the maximum digits per code; SHALL be >= 1.
REQ-002 Parameter DIGIT_W, default 4, is the bit width of one digit value; SHALL be >= 1.
REQ-003 Derived LEN_W = $clog2(MAX_LEN+1) SHALL size all length fields.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 d_valid  input  1  digit strobe, one digit per high cycle.
REQ-007 d_val  input  DIGIT_W  digit value, sampled when d_valid=1.
REQ-008 c_done  input  1  code-complete strobe.
REQ-009 len  output  LEN_W  live count of digits accepted in the current code.
REQ-010 code_out  output  MAX_LEN*DIGIT_W  last completed code, right-justified, unused upper digits zero.
REQ-011 code_len  output  LEN_W  digit count of last completed code.
REQ-012 code_ovf  output  1  last completed code had digits dropped.
REQ-013 code_valid  output  1  one-cycle pulse: new code on code_out/code_len/code_ovf.
REQ-014 empty_err  output  1  one-cycle pulse: completion with zero digits.

Function
REQ-015 FSM states SHALL be S_IDLE (len=0), S_COLLECT (1..MAX_LEN-1), S_FULL (len=MAX_LEN); len SHALL be a Moore output of the registered count.
REQ-016 Accepted digit: buffer shifts left by DIGIT_W, d_val enters the low digit, count +1.
REQ-017 S_IDLE: d_valid -> accept, go S_COLLECT (S_FULL if MAX_LEN=1); c_done alone -> stay, empty_err=1 next cycle.
REQ-018 S_COLLECT: d_valid -> accept; count reaching MAX_LEN -> S_FULL, else stay.
REQ-019 S_FULL: d_valid -> digit dropped, sticky overflow flag set, count unchanged.
REQ-020 Completion in S_COLLECT/S_FULL: code_out<=buffer, code_len<=count, code_ovf<=overflow flag, code_valid=1 next cycle; buffer, count, flag cleared; go S_IDLE.
REQ-021 d_valid and c_done same cycle: digit processed first (accepted or dropped per state), then completion uses the updated buffer/count/flag; in S_IDLE this yields code_len=1, no empty_err.
REQ-022 Latency: code_valid/empty_err high exactly the cycle after the c_done cycle; len reads 0 in that cycle.
REQ-023 code_out, code_len, code_ovf SHALL hold until the next successful completion; empty_err SHALL NOT alter them.
REQ-024 Inputs with both strobes low SHALL leave all state unchanged.
REQ-025 Count SHALL never exceed MAX_LEN; no wrap-around.

Reset
REQ-026 Reset SHALL force S_IDLE, len=0, buffer=0, overflow flag=0, code_out=0, code_len=0, code_ovf=0, code_valid=0, empty_err=0.
REQ-027 Reset mid-code SHALL discard the partial code without any code_valid pulse.
REQ-028 First action after reset release SHALL be evaluated on the first clk rising edge with reset low.

Structure
REQ-029 State enum and a LEN_W helper function SHALL live in shared package sticker_pkg.
REQ-030 Digit storage SHALL be sub-module digit_shift_buffer (parameters MAX_LEN, DIGIT_W; ports clk, reset, shift, clear, din, dout).
REQ-031 All outputs SHALL be driven from registers; no combinational input-to-output path.

Verification (MAX_LEN=3, DIGIT_W=4)
REQ-032 Digits 0x7, 0x2 then c_done -> next cycle code_valid=1, code_out=0x072, code_len=2, code_ovf=0, len=0.
REQ-033 Digits 1,2,3,4,5 then c_done -> len saturates at 3; code_out=0x123, code_len=3, code_ovf=1.
REQ-034 c_done in S_IDLE -> empty_err=1 one cycle, code_valid=0, prior code_out unchanged.
REQ-035 Digit 0x9 with c_done same cycle in S_IDLE -> code_out=0x009, code_len=1, no empty_err; digits 1,2 then 3+c_done together -> code_out=0x123, code_ovf=0.
REQ-036 Digits 0x5, 0x6 then reset pulse mid-cycle -> all outputs 0 immediately, no code_valid; following 0x8+c_done -> code_out=0x008, code_len=1.
REQ-037 MAX_LEN=1 build: digits 0xA, 0xB then c_done -> code_out=0xA, code_len=1, code_ovf=1.
